// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// Emulates the output side of the serial ADC. It watches the chip-select and
// SPI clock driven by the SIPO capture controller and shifts a sample out on
// sdata in the ADC frame format: LEAD_ZEROS zero bits, the sample MSB-first,
// then zeros until CS rises.
//
// Ports:
//   clk         system clock (must be >= 4x the SPI clock)
//   reset_b     asynchronous active-low reset
//   cs_in       chip select, active low, asynchronous to clk
//   spi_clk_in  SPI clock, asynchronous to clk; sdata changes after falls
//   use_ext     1 = serialise sample_in, 0 = serialise the internal ramp
//   sample_in   external sample, latched when a frame starts
//   sdata       serial data towards the SIPO data input
//   busy        high while a frame is in progress
//   frame_done  one-clk pulse when a frame ends after the last data bit
//   frame_abort one-clk pulse when CS rises before the last data bit
//   ramp_value  current internal ramp sample
module adc_spi_responder #(
    parameter int DATA_WIDTH = 10,
    parameter int LEAD_ZEROS = 3,
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  cs_in,
    input  logic                  spi_clk_in,
    input  logic                  use_ext,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic                  sdata,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic [DATA_WIDTH-1:0] ramp_value
);

    localparam int IDX_W    = $clog2(FRAME_BITS + 1);
    // Index of the last sample bit; a frame is complete once it was presented.
    localparam int LAST_BIT = LEAD_ZEROS + DATA_WIDTH - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Synchroniser stages plus a history stage for edge detection.
    logic r_cs_meta, r_cs_sync, r_cs_hist;
    logic r_sck_meta, r_sck_sync, r_sck_hist;

    state_t                r_state,   w_state_nx;
    logic [IDX_W-1:0]      r_bit_idx, w_bit_idx_nx;
    logic [DATA_WIDTH-1:0] r_shift,   w_shift_nx;
    logic                  r_ext_lat, w_ext_lat_nx;
    logic                  r_sdata,   w_sdata_nx;
    logic                  r_busy,    w_busy_nx;
    logic                  r_done,    w_done_nx;
    logic                  r_abort,   w_abort_nx;
    logic [DATA_WIDTH-1:0] r_ramp,    w_ramp_nx;
    logic                  r_armed,   w_armed_nx;

    logic w_cs_fall, w_cs_rise, w_sck_fall;

    assign w_cs_fall  =  r_cs_hist & ~r_cs_sync;
    assign w_cs_rise  = ~r_cs_hist &  r_cs_sync;
    assign w_sck_fall =  r_sck_hist & ~r_sck_sync;

    // Serial bit presented at frame index k for latched sample s.
    function automatic logic bit_at(input logic [IDX_W-1:0] k,
                                    input logic [DATA_WIDTH-1:0] s);
        int                    ki;
        logic [DATA_WIDTH-1:0] s_shl;
        ki    = int'(k);
        s_shl = '0;
        if (ki >= LEAD_ZEROS && ki <= LAST_BIT) begin
            s_shl = s << (ki - LEAD_ZEROS);
        end
        return s_shl[DATA_WIDTH-1];
    endfunction

    // Synchronisers reset low so that a CS already low at reset release is
    // never mistaken for a falling edge while armed.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cs_meta  <= 1'b0;
            r_cs_sync  <= 1'b0;
            r_cs_hist  <= 1'b0;
            r_sck_meta <= 1'b0;
            r_sck_sync <= 1'b0;
            r_sck_hist <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous
            // stage's old value, giving a real flop chain rather than one wire.
            r_cs_meta  <= cs_in;
            r_cs_sync  <= r_cs_meta;
            r_cs_hist  <= r_cs_sync;
            r_sck_meta <= spi_clk_in;
            r_sck_sync <= r_sck_meta;
            r_sck_hist <= r_sck_sync;
        end
    end

    always_comb begin
        // NOTE: every next-value gets a default first so no path through the
        // case statement leaves a variable unassigned (no latch inferred).
        w_state_nx   = r_state;
        w_bit_idx_nx = r_bit_idx;
        w_shift_nx   = r_shift;
        w_ext_lat_nx = r_ext_lat;
        w_sdata_nx   = r_sdata;
        w_busy_nx    = r_busy;
        w_done_nx    = 1'b0;
        w_abort_nx   = 1'b0;
        w_ramp_nx    = r_ramp;
        w_armed_nx   = r_armed | r_cs_sync;

        case (r_state)
            IDLE: begin
                w_sdata_nx = 1'b0;
                w_busy_nx  = 1'b0;
                if (w_cs_fall && r_armed) begin
                    w_shift_nx   = use_ext ? sample_in : r_ramp;
                    w_ext_lat_nx = use_ext;
                    w_bit_idx_nx = '0;
                    w_busy_nx    = 1'b1;
                    w_state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                // CS rise takes priority over a coincident SCLK fall, so the
                // completeness check sees the index before any increment.
                if (w_cs_rise) begin
                    w_state_nx = IDLE;
                    w_busy_nx  = 1'b0;
                    w_sdata_nx = 1'b0;
                    if (int'(r_bit_idx) >= LAST_BIT) begin
                        w_done_nx = 1'b1;
                        if (!r_ext_lat) begin
                            w_ramp_nx = r_ramp + DATA_WIDTH'(1);
                        end
                    end else begin
                        w_abort_nx = 1'b1;
                    end
                end else if (w_sck_fall) begin
                    if (int'(r_bit_idx) < FRAME_BITS) begin
                        w_bit_idx_nx = r_bit_idx + IDX_W'(1);
                    end
                    w_sdata_nx = bit_at(w_bit_idx_nx, r_shift);
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_ext_lat <= 1'b0;
            r_sdata   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
            r_ramp    <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_idx <= w_bit_idx_nx;
            r_shift   <= w_shift_nx;
            r_ext_lat <= w_ext_lat_nx;
            r_sdata   <= w_sdata_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            r_abort   <= w_abort_nx;
            r_ramp    <= w_ramp_nx;
            r_armed   <= w_armed_nx;
        end
    end

    assign sdata       = r_sdata;
    assign busy        = r_busy;
    assign frame_done  = r_done;
    assign frame_abort = r_abort;
    assign ramp_value  = r_ramp;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Testbench for adc_spi_responder. Acts as the SIPO controller: drives CS and
// SCLK on clk-aligned boundaries, samples sdata just before each SCLK rise
// and compares against frames built from the ADC frame format. The ramp and
// the frame outcome are tracked by a small behavioural model.
module tb_adc_spi_responder;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset_b;
    logic          cs_in;
    logic          spi_clk_in;
    logic          use_ext;
    logic [DW-1:0] sample_in;
    logic          sdata;
    logic          busy;
    logic          frame_done;
    logic          frame_abort;
    logic [DW-1:0] ramp_value;

    int n_cmp = 0;
    int n_bad = 0;
    int done_total = 0;
    int abort_total = 0;
    int m_ramp = 0;

    always #5 clk = ~clk;

    adc_spi_responder #(
        .DATA_WIDTH (DW),
        .LEAD_ZEROS (3),
        .FRAME_BITS (16)
    ) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .cs_in       (cs_in),
        .spi_clk_in  (spi_clk_in),
        .use_ext     (use_ext),
        .sample_in   (sample_in),
        .sdata       (sdata),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .ramp_value  (ramp_value)
    );

    always @(negedge clk) begin
        if (frame_done)  done_total  <= done_total + 1;
        if (frame_abort) abort_total <= abort_total + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected 16-bit serial word: 3 lead zeros, sample MSB-first, 3 zeros.
    function automatic logic [15:0] frame_word(input logic [DW-1:0] v);
        return {3'b000, v, 3'b000};
    endfunction

    // One frame as the SIPO controller would run it: CS low, n_falls SCLK
    // periods (rise then fall, hp clk per half), CS high. sdata is sampled
    // before each rise into cap, MSB first. sample_in changes to chg_val
    // after chg_at falls (chg_at < 0 disables that).
    task automatic run_frame(input int n_falls, input int hp, input int chg_at,
                             input logic [DW-1:0] chg_val,
                             output logic [15:0] cap, output logic busy_mid);
        cap      = '0;
        busy_mid = 1'b0;
        cs_in    = 1'b0;
        wait_clks(hp);
        for (int i = 0; i < n_falls; i++) begin
            if (i < 16) cap[15-i] = sdata;
            if (i == n_falls / 2) busy_mid = busy;
            spi_clk_in = 1'b1;
            wait_clks(hp);
            spi_clk_in = 1'b0;
            wait_clks(hp);
            if (i + 1 == chg_at) sample_in = chg_val;
        end
        wait_clks(hp);
        cs_in = 1'b1;
        wait_clks(hp + 4);
    endtask

    task automatic test_reset();
        reset_b    = 1'b0;
        cs_in      = 1'b1;
        spi_clk_in = 1'b0;
        use_ext    = 1'b0;
        sample_in  = '0;
        wait_clks(3);
        n_cmp++;
        if ({sdata, busy, frame_done, frame_abort} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000",
                     {sdata, busy, frame_done, frame_abort});
        end
        n_cmp++;
        if (ramp_value !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_ramp: got %0d want 0", ramp_value);
        end
        reset_b = 1'b1;
        wait_clks(6);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
        m_ramp = 0;
    endtask

    task automatic test_ramp_frame();
        logic [15:0] cap;
        logic        bm;
        int          d0, a0;
        d0 = done_total;
        a0 = abort_total;
        use_ext = 1'b0;
        run_frame(16, 7, -1, '0, cap, bm);
        n_cmp++;
        if (cap !== frame_word(DW'(m_ramp))) begin
            n_bad++;
            $display("FAIL ramp_capture: got %h want %h", cap, frame_word(DW'(m_ramp)));
        end
        n_cmp++;
        if (bm !== 1'b1) begin
            n_bad++;
            $display("FAIL ramp_busy_mid: got %b want 1", bm);
        end
        n_cmp++;
        if (done_total - d0 != 1 || abort_total - a0 != 0) begin
            n_bad++;
            $display("FAIL ramp_pulses: got done=%0d abort=%0d want 1/0",
                     done_total - d0, abort_total - a0);
        end
        m_ramp = (m_ramp + 1) % 1024;
        n_cmp++;
        if (ramp_value !== DW'(m_ramp)) begin
            n_bad++;
            $display("FAIL ramp_incr: got %0d want %0d", ramp_value, m_ramp);
        end
    endtask

    task automatic test_ext_pattern();
        logic [15:0] cap;
        logic        bm;
        use_ext   = 1'b1;
        sample_in = 10'h2A5;
        run_frame(16, 7, -1, '0, cap, bm);
        n_cmp++;
        if (cap !== 16'h1528) begin
            n_bad++;
            $display("FAIL ext_bitstream: got %b want %b", cap, 16'h1528);
        end
        n_cmp++;
        if (cap[12:3] !== 10'h2A5) begin
            n_bad++;
            $display("FAIL ext_value: got %h want 2a5", cap[12:3]);
        end
        n_cmp++;
        if (ramp_value !== DW'(m_ramp)) begin
            n_bad++;
            $display("FAIL ext_ramp_hold: got %0d want %0d", ramp_value, m_ramp);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] cap;
        logic        bm;
        int          d0, n_fast;
        use_ext = 1'b0;
        d0      = done_total;
        n_fast  = 1023 - m_ramp;
        // Fast minimal-length complete frames to walk the ramp up to 1023.
        for (int f = 0; f < n_fast; f++) begin
            run_frame(12, 2, -1, '0, cap, bm);
            m_ramp = (m_ramp + 1) % 1024;
        end
        n_cmp++;
        if (done_total - d0 != n_fast || ramp_value !== DW'(m_ramp)) begin
            n_bad++;
            $display("FAIL wrap_preload: got done=%0d ramp=%0d want %0d/%0d",
                     done_total - d0, ramp_value, n_fast, m_ramp);
        end
        run_frame(16, 7, -1, '0, cap, bm);
        n_cmp++;
        if (cap[12:3] !== 10'h3FF) begin
            n_bad++;
            $display("FAIL wrap_capture_max: got %h want 3ff", cap[12:3]);
        end
        m_ramp = (m_ramp + 1) % 1024;
        n_cmp++;
        if (ramp_value !== DW'(m_ramp)) begin
            n_bad++;
            $display("FAIL wrap_to_zero: got %0d want %0d", ramp_value, m_ramp);
        end
        run_frame(16, 7, -1, '0, cap, bm);
        n_cmp++;
        if (cap[12:3] !== 10'h000) begin
            n_bad++;
            $display("FAIL wrap_capture_zero: got %h want 000", cap[12:3]);
        end
        m_ramp = (m_ramp + 1) % 1024;
    endtask

    task automatic test_abort();
        logic [15:0] cap;
        logic        bm;
        int          d0, a0;
        use_ext = 1'b0;
        while (m_ramp != 5) begin
            run_frame(12, 2, -1, '0, cap, bm);
            m_ramp = (m_ramp + 1) % 1024;
        end
        d0 = done_total;
        a0 = abort_total;
        cs_in = 1'b0;
        wait_clks(7);
        for (int i = 0; i < 8; i++) begin
            spi_clk_in = 1'b1;
            wait_clks(7);
            spi_clk_in = 1'b0;
            wait_clks(7);
        end
        cs_in = 1'b1;
        wait_clks(4);
        n_cmp++;
        if (sdata !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: got sdata=%b busy=%b want 0/0", sdata, busy);
        end
        wait_clks(6);
        n_cmp++;
        if (abort_total - a0 != 1 || done_total - d0 != 0) begin
            n_bad++;
            $display("FAIL abort_pulses: got abort=%0d done=%0d want 1/0",
                     abort_total - a0, done_total - d0);
        end
        n_cmp++;
        if (ramp_value !== 10'd5) begin
            n_bad++;
            $display("FAIL abort_ramp_hold: got %0d want 5", ramp_value);
        end
    endtask

    task automatic test_sample_change();
        logic [15:0] cap;
        logic        bm;
        use_ext   = 1'b1;
        sample_in = 10'h155;
        run_frame(16, 7, 5, 10'h0AA, cap, bm);
        n_cmp++;
        if (cap[12:3] !== 10'h155) begin
            n_bad++;
            $display("FAIL change_inflight: got %h want 155", cap[12:3]);
        end
        run_frame(16, 7, -1, '0, cap, bm);
        n_cmp++;
        if (cap[12:3] !== 10'h0AA) begin
            n_bad++;
            $display("FAIL change_next: got %h want 0aa", cap[12:3]);
        end
    endtask

    // Reset mid-frame with CS held low through the release: no frame until
    // CS has been seen high and then low again.
    task automatic test_cs_low_reset();
        int a0;
        use_ext = 1'b0;
        cs_in   = 1'b0;
        wait_clks(7);
        spi_clk_in = 1'b1;
        wait_clks(4);
        spi_clk_in = 1'b0;
        wait_clks(4);
        reset_b = 1'b0;
        wait_clks(3);
        reset_b = 1'b1;
        m_ramp  = 0;
        wait_clks(8);
        for (int i = 0; i < 3; i++) begin
            spi_clk_in = 1'b1;
            wait_clks(4);
            spi_clk_in = 1'b0;
            wait_clks(4);
        end
        n_cmp++;
        if (busy !== 1'b0 || ramp_value !== 10'd0) begin
            n_bad++;
            $display("FAIL cslow_no_frame: got busy=%b ramp=%0d want 0/0", busy, ramp_value);
        end
        cs_in = 1'b1;
        wait_clks(6);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cslow_high_idle: got busy=%b want 0", busy);
        end
        a0    = abort_total;
        cs_in = 1'b0;
        wait_clks(5);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL cslow_frame_start: got busy=%b want 1", busy);
        end
        cs_in = 1'b1;
        wait_clks(8);
        n_cmp++;
        if (abort_total - a0 != 1 || ramp_value !== 10'd0) begin
            n_bad++;
            $display("FAIL cslow_abort: got aborts=%0d ramp=%0d want 1/0",
                     abort_total - a0, ramp_value);
        end
    endtask

    task automatic test_random();
        logic [15:0]   cap, mask, ones, expw;
        logic          bm;
        logic          ext;
        logic [DW-1:0] smp, val;
        int            nf, hp, d0, a0;
        bit            complete;
        ones = 16'hFFFF;
        for (int f = 0; f < 24; f++) begin
            ext       = 1'($urandom_range(0, 1));
            smp       = DW'($urandom);
            nf        = $urandom_range(8, 16);
            hp        = $urandom_range(5, 8);
            use_ext   = ext;
            sample_in = smp;
            val       = ext ? smp : DW'(m_ramp);
            complete  = (nf >= 12);
            d0 = done_total;
            a0 = abort_total;
            run_frame(nf, hp, -1, '0, cap, bm);
            mask = ~(ones >> nf);
            expw = frame_word(val) & mask;
            n_cmp++;
            if ((cap & mask) !== expw) begin
                n_bad++;
                $display("FAIL rand_bits[%0d]: got %h want %h (n=%0d)", f, cap & mask, expw, nf);
            end
            n_cmp++;
            if (done_total - d0 != (complete ? 1 : 0) ||
                abort_total - a0 != (complete ? 0 : 1)) begin
                n_bad++;
                $display("FAIL rand_outcome[%0d]: got done=%0d abort=%0d (n=%0d)",
                         f, done_total - d0, abort_total - a0, nf);
            end
            if (complete && !ext) m_ramp = (m_ramp + 1) % 1024;
            n_cmp++;
            if (ramp_value !== DW'(m_ramp)) begin
                n_bad++;
                $display("FAIL rand_ramp[%0d]: got %0d want %0d", f, ramp_value, m_ramp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_frame();
        test_ext_pattern();
        test_wrap();
        test_abort();
        test_sample_change();
        test_cs_low_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
